ram_tx_reader: RTL and testbench
================================

# ram_tx_reader

Streams a contiguous block of bytes out of the design's synchronous byte RAM into the UART transmit channel. It is the read-side counterpart of the receive path, which writes each received byte into RAM. On a start request the block reads `len` bytes from address `base` upward, with address wrap-around. Each byte is presented to the UART TX interface with a valid/ready handshake, and `done` is pulsed at the end.

## Interface
Parameters:
- `ADDR_W`, 8: RAM address width; RAM depth is 2^ADDR_W.
- `DATA_W`, 8: byte width; must match the UART TX data width.

Ports:
- `clock`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base`  in  ADDR_W  first RAM address; latched on accepted start.
- `len`  in  ADDR_W+1  byte count, 0..2^ADDR_W; latched on accepted start.
- `ram_addr`  out  ADDR_W  RAM read address.
- `ram_dout`  in  DATA_W  RAM read data, valid one cycle after `ram_addr`.
- `tx_data`  out  DATA_W  byte offered to the UART TX.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  UART TX accepts the byte this cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the transfer completes.

## Operation
- States: IDLE, FETCH, LOAD, SEND, CSUM (checksum builds only), DONE.
- IDLE:
  - `start`=1 latches `base` into the address counter and `len` into the remaining counter, and clears the checksum.
  - If `len`≠0, go to FETCH.
  - If `len`=0, go to CSUM in checksum builds, otherwise to DONE.
- FETCH: `ram_addr` = address counter for one cycle.
- LOAD:
  - Capture `ram_dout` into the `tx_data` register.
  - Add it to the checksum (mod 2^DATA_W).
  - Increment the address, wrapping 2^ADDR_W−1 → 0.
  - Decrement the remaining count.
- SEND:
  - `tx_valid`=1 and hold until `tx_valid && tx_ready`.
  - On that handshake, go to FETCH if remaining≠0. Otherwise go to CSUM in checksum builds, or to DONE without checksum.
- CSUM: `tx_data` = checksum and `tx_valid`=1. On the handshake, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored whenever not in IDLE. `base` and `len` are not re-sampled mid-transfer.
- `tx_data` stays stable while `tx_valid && !tx_ready`. `tx_valid` never drops before a handshake.
- `ram_addr` outside FETCH holds its last value; the block is read-only toward RAM.
- Reset:
  - Outputs: `tx_valid`=0, `done`=0, `busy`=0, `tx_data`=0, `ram_addr`=0.
  - Internal: state IDLE, counters 0, checksum 0.
  - Reset mid-transfer aborts at the next edge. No `done` is produced and no further bytes are sent.

## Timing
- `start` sampled at edge 0 → FETCH in cycle 1, LOAD in cycle 2, `tx_valid` first high in cycle 3.
- Per-byte cost: 3 cycles plus any `tx_ready` stall. Next `tx_valid` comes 3 cycles after the handshake edge.
- `done` rises in the cycle after the final handshake. `busy` falls in the cycle after `done`.
- `len`=0 without checksum: `done` in cycle 1, no bytes sent.
- `tx_ready` high before `tx_valid` has no effect.
- `tx_ready` held high continuously sustains 1 byte per 3 cycles.

## Configuration
- `RAM_TX_READER_CHECKSUM_EN` defined: CSUM state present. One extra byte follows the data bytes, equal to the 8-bit modular sum of all bytes sent. For `len`=0 this byte is 0x00.
- Macro undefined: no CSUM state and no checksum register. The byte stream is exactly `len` bytes.

## Structure
- Shared package `uart_ram_pkg` holds:
  - the state enum typedef;
  - default `ADDR_W` and `DATA_W` constants, shared with the RAM and UART instances.
- Single module; no sub-module. The counters, FSM and output register fit cleanly in one file.

## Test plan
- RAM preloaded with 0x30..0x33, `base`=0, `len`=4, `tx_ready`=1 → TX sees 0x30,0x31,0x32,0x33. First `tx_valid` in cycle 3; single `done` pulse.
- `base`=0xFE, `len`=4, RAM[0xFE]=0xA0, RAM[0xFF]=0xA1, RAM[0x00]=0xA2, RAM[0x01]=0xA3 → TX sees 0xA0,0xA1,0xA2,0xA3 (address wraps).
- `tx_ready` held low 20 cycles during the second byte → `tx_data` and `tx_valid` stable throughout; no byte lost or duplicated.
- `len`=0 → no `tx_valid`; `done` in cycle 1. With the macro defined, exactly one byte 0x00 is sent, then `done`.
- Checksum build, bytes 0xFF,0x02 → TX sees 0xFF,0x02,0x01.
- Reset asserted during SEND of byte 2 of 4 → next cycle `tx_valid`=0, `busy`=0, no `done`. A new start then transfers normally; repeated `start` pulses while busy are ignored.

Source files
------------

// File: rtl/uart_ram_pkg.sv
// Shared types and default widths for the UART <-> byte RAM datapath.
// RAM_TX_READER_CHECKSUM_EN adds the CSUM state to the reader FSM.
package uart_ram_pkg;

   localparam int UART_RAM_ADDR_W = 8;
   localparam int UART_RAM_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_SEND,
`ifdef RAM_TX_READER_CHECKSUM_EN
      ST_CSUM,
`endif
      ST_DONE
   } state_e;

endpackage

// File: rtl/ram_tx_reader.sv
// Streams len bytes from RAM[base..] (wrapping) to the UART TX handshake.
// RAM_TX_READER_CHECKSUM_EN appends an 8-bit modular sum of the bytes sent.
module ram_tx_reader
   import uart_ram_pkg::*;
#(
   parameter int ADDR_W = UART_RAM_ADDR_W,
   parameter int DATA_W = UART_RAM_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   len,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done
);

`ifdef RAM_TX_READER_CHECKSUM_EN
   localparam state_e TAIL_ST = ST_CSUM;
`else
   localparam state_e TAIL_ST = ST_DONE;
`endif

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [DATA_W-1:0] data_q, data_d;
`ifdef RAM_TX_READER_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         raddr_q <= '0;
         rem_q   <= '0;
         data_q  <= '0;
`ifdef RAM_TX_READER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         raddr_q <= raddr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
`ifdef RAM_TX_READER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      raddr_d = raddr_q;
      rem_d   = rem_q;
      data_d  = data_q;
`ifdef RAM_TX_READER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d  = base;
               rem_d   = len;
`ifdef RAM_TX_READER_CHECKSUM_EN
               csum_d  = '0;
`endif
               state_d = (len != '0) ? ST_FETCH : TAIL_ST;
            end
         end
         ST_FETCH: begin
            raddr_d = addr_q;
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            data_d  = ram_dout;
`ifdef RAM_TX_READER_CHECKSUM_EN
            csum_d  = csum_q + ram_dout;
`endif
            // Natural overflow of the ADDR_W counter gives the wrap.
            addr_d  = addr_q + ADDR_W'(1);
            rem_d   = rem_q - (ADDR_W+1)'(1);
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (tx_ready)
               state_d = (rem_q != '0) ? ST_FETCH : TAIL_ST;
         end
`ifdef RAM_TX_READER_CHECKSUM_EN
         ST_CSUM: begin
            if (tx_ready)
               state_d = ST_DONE;
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // raddr_q keeps the last fetched address visible outside FETCH.
   assign ram_addr = (state_q == ST_FETCH) ? addr_q : raddr_q;

`ifdef RAM_TX_READER_CHECKSUM_EN
   assign tx_valid = (state_q == ST_SEND) || (state_q == ST_CSUM);
   assign tx_data  = (state_q == ST_CSUM) ? csum_q : data_q;
`else
   assign tx_valid = (state_q == ST_SEND);
   assign tx_data  = data_q;
`endif

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_ram_tx_reader.sv
// Directed bench for ram_tx_reader: vector table plus reset/abort sequence.
// Expected streams include the checksum byte when the macro is defined.
module tb_ram_tx_reader;

   localparam int AW = 8;
   localparam int DW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base  = '0;
   logic [AW:0]   len   = '0;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dout = '0;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b0;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mem [256];

   always #5 clock = ~clock;

   always @(posedge clock) ram_dout <= mem[ram_addr];

   ram_tx_reader dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .base     (base),
      .len      (len),
      .ram_addr (ram_addr),
      .ram_dout (ram_dout),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .done     (done)
   );

   typedef struct packed {
      logic [7:0]  base;
      logic [8:0]  len;
      logic [31:0] d;
      int          stall_idx;
      int          stall_cyc;
      bit          spam;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] dbyte(input logic [31:0] d, input int i);
      return d[31-8*i -: 8];
   endfunction

   task automatic run_xfer(input vec_t v);
      logic [7:0] exp [$];
      logic [7:0] sum;
      int cyc, idx, prev_hs, stalls, got_done, gap;
      sum = '0;
      for (int i = 0; i < int'(v.len); i++) begin
         mem[8'(v.base + 8'(i))] = dbyte(v.d, i);
         exp.push_back(dbyte(v.d, i));
         sum = sum + dbyte(v.d, i);
      end
`ifdef RAM_TX_READER_CHECKSUM_EN
      exp.push_back(sum);
`endif
      @(negedge clock);
      base = v.base; len = v.len; start = 1'b1; tx_ready = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 1; idx = 0; prev_hs = 0; stalls = 0; got_done = 0;
      while (cyc < 300 && got_done == 0) begin
         if (v.spam && cyc >= 2 && cyc <= 5) begin
            start = 1'b1; base = 8'hEE; len = 9'd7;
         end else begin
            start = 1'b0;
         end
         tx_ready = !(idx == v.stall_idx && stalls < v.stall_cyc);
         if (tx_valid) begin
            if (idx < exp.size())
               chk("tx_data", int'(tx_data), int'(exp[idx]));
            else
               chk("extra byte", 1, 0);
         end
         if (tx_valid && !tx_ready) stalls++;
         if (tx_valid && tx_ready) begin
            gap = (idx < int'(v.len)) ? 3 : 1;
            chk("hs cycle", cyc, prev_hs + gap + stalls);
            prev_hs = cyc; stalls = 0; idx++;
         end
         if (done) begin
            got_done = 1;
            chk("done cycle", cyc, prev_hs + 1);
            chk("byte count", idx, exp.size());
            chk("busy at done", int'(busy), 1);
            @(negedge clock);
            start = 1'b0;
            chk("done width", int'(done), 0);
            chk("busy after", int'(busy), 0);
            chk("valid after", int'(tx_valid), 0);
         end else begin
            @(negedge clock);
            cyc++;
         end
      end
      if (got_done == 0) chk("done timeout", 0, 1);
      start = 1'b0;
      tx_ready = 1'b1;
   endtask

   task automatic reset_abort();
      int cyc, idx, seen;
      for (int i = 0; i < 4; i++) mem[8'h60 + 8'(i)] = 8'h70 + 8'(i);
      @(negedge clock);
      base = 8'h60; len = 9'd4; start = 1'b1; tx_ready = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 1; idx = 0; seen = 0;
      while (cyc < 100 && seen == 0) begin
         if (tx_valid && idx == 1) begin
            seen = 1;
            tx_ready = 1'b0;
            chk("abort byte2", int'(tx_data), 8'h71);
         end else begin
            if (tx_valid && tx_ready) idx++;
            @(negedge clock);
            cyc++;
         end
      end
      if (seen == 0) chk("abort timeout", 0, 1);
      reset = 1'b1;
      @(negedge clock);
      chk("abort valid", int'(tx_valid), 0);
      chk("abort busy", int'(busy), 0);
      chk("abort done", int'(done), 0);
      reset = 1'b0;
      tx_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (tx_valid || done || busy) seen = 1;
      end
      chk("quiet after abort", seen, 0);
   endtask

   initial begin
      tbl[0] = '{base: 8'h00, len: 9'd4, d: 32'h30313233,
                 stall_idx: -1, stall_cyc: 0, spam: 1'b0};
      tbl[1] = '{base: 8'hFE, len: 9'd4, d: 32'hA0A1A2A3,
                 stall_idx: -1, stall_cyc: 0, spam: 1'b0};
      tbl[2] = '{base: 8'h40, len: 9'd4, d: 32'h11223344,
                 stall_idx: 1, stall_cyc: 20, spam: 1'b0};
      tbl[3] = '{base: 8'h80, len: 9'd0, d: 32'h0,
                 stall_idx: -1, stall_cyc: 0, spam: 1'b0};
      tbl[4] = '{base: 8'h90, len: 9'd2, d: 32'hFF020000,
                 stall_idx: -1, stall_cyc: 0, spam: 1'b0};
      tbl[5] = '{base: 8'h20, len: 9'd1, d: 32'h5A000000,
                 stall_idx: 0, stall_cyc: 3, spam: 1'b0};

      for (int i = 0; i < 256; i++) mem[i] = 8'hCC;

      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst tx_valid", int'(tx_valid), 0);
      chk("rst done", int'(done), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst tx_data", int'(tx_data), 0);
      chk("rst ram_addr", int'(ram_addr), 0);
      reset = 1'b0;
      tx_ready = 1'b1;

      for (int i = 0; i < 6; i++) run_xfer(tbl[i]);

      reset_abort();
      tbl[0].spam = 1'b1;
      run_xfer(tbl[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
